block_mem_cfg: RTL and testbench

Parametrised, configurable memory tile for the fabric, generalising the single-bit-configured block memory with selectable width and depth. A multi-bit configuration word is shifted in serially on the fabric clock and selects one of two operating modes: addressed RAM or first-word-fall-through FIFO. Both modes use valid/ready handshakes on the input and output sides. The tile sits in the fabric array beside the compute blocks, and its config_in/config_out pins chain with the neighbouring tiles.

---
 rtl/block_mem_cfg.sv | 179 +++++++++++++++++
 tb/tb_block_mem_cfg.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_mem_cfg.sv
// -----------------------------------------------------------------------------
// block_mem_cfg
//   Configurable memory tile for the fabric array. A 3-bit configuration word
//   is shifted in serially and selects addressed-RAM or first-word-fall-through
//   FIFO operation. Both sides use valid/ready handshakes.
//
//   cfg[0]   : enable
//   cfg[2:1] : mode (01 RAM, 10 FIFO, 00/11 disabled)
//
// Ports
//   clk        : single clock for config chain and datapath
//   reset      : asynchronous, active-low reset
//   config_en  : shift enable for the configuration chain
//   config_in  : serial configuration data in
//   config_out : serial configuration data out (cfg[0]) to the next tile
//   in0        : RAM address (bits [AW-1:0]) / FIFO push data
//   in1        : RAM write data (unused in FIFO mode)
//   we         : RAM write flag (1 write, 0 read)
//   in_valid   : request / push valid
//   in_ready   : request / push accepted when in_valid & in_ready
//   out0       : read data or FIFO head, zero when out_valid is low
//   out_valid  : out0 holds valid data
//   out_ready  : consumer accepts out0 when out_valid & out_ready
// -----------------------------------------------------------------------------
module block_mem_cfg #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             config_en,
  input  logic             config_in,
  output logic             config_out,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             we,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RAM  = 2'b01,
    MODE_FIFO = 2'b10,
    MODE_BAD  = 2'b11
  } mode_e;

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [2:0]       r_cfg;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;

  mode_e            w_mode;
  logic             w_ram;
  logic             w_fifo;
  logic [AW-1:0]    w_addr;
  logic             w_full;
  logic             w_empty;
  logic             w_accept;
  logic             w_ram_wr;
  logic             w_ram_rd;
  logic             w_push;
  logic             w_pop;
  logic             w_mem_we;
  logic [AW-1:0]    w_mem_waddr;
  logic [WIDTH-1:0] w_mem_wdata;
  logic             w_unused_in0_hi;

  // Only the low AW bits of in0 address the RAM.
  assign w_unused_in0_hi = ^in0[WIDTH-1:AW];

  assign w_mode     = mode_e'(r_cfg[2:1]);
  assign w_ram      = r_cfg[0] && (w_mode == MODE_RAM);
  assign w_fifo     = r_cfg[0] && (w_mode == MODE_FIFO);
  assign w_addr     = in0[AW-1:0];
  assign w_full     = (r_count == FULL_COUNT);
  assign w_empty    = (r_count == '0);
  assign config_out = r_cfg[0];

  // Handshake decode. A config shift cycle blocks every transfer.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out0      = '0;
    if (w_ram) begin
      in_ready  = !config_en && (!r_rd_valid || out_ready);
      out_valid = r_rd_valid;
      if (r_rd_valid) out0 = r_rd_data;
    end else if (w_fifo) begin
      in_ready  = !config_en && !w_full;
      out_valid = !w_empty;
      if (!w_empty) out0 = r_mem[r_rd_ptr];
    end
  end

  assign w_accept = in_valid && in_ready;
  assign w_ram_wr = w_ram  && w_accept && we;
  assign w_ram_rd = w_ram  && w_accept && !we;
  assign w_push   = w_fifo && w_accept;
  assign w_pop    = w_fifo && !w_empty && out_ready && !config_en;

  // One shared write port serves both modes.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = '0;
    w_mem_wdata = '0;
    if (w_ram_wr) begin
      w_mem_we    = 1'b1;
      w_mem_waddr = w_addr;
      w_mem_wdata = in1;
    end else if (w_push) begin
      w_mem_we    = 1'b1;
      w_mem_waddr = r_wr_ptr;
      w_mem_wdata = in0;
    end
  end

  // Storage is never reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
  end

  // Configuration shift chain: first bit shifted ends up in cfg[0].
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cfg <= '0;
    end else if (config_en) begin
      r_cfg <= {config_in, r_cfg[2:1]};
    end
  end

  // RAM output register. Reads sample the array before any same-edge write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else if (config_en) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else if (w_ram_rd) begin
      r_rd_data  <= r_mem[w_addr];
      r_rd_valid <= 1'b1;
    end else if (r_rd_valid && out_ready) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (config_en) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_block_mem_cfg.sv
// -----------------------------------------------------------------------------
// tb_block_mem_cfg
//   Scoreboard bench for block_mem_cfg. The driver predicts in_ready and
//   config_out from a behavioural model (bit history, word array, queue of
//   expected outputs); a separate monitor compares every presented output
//   against the head of the expected queue.
// -----------------------------------------------------------------------------
module tb_block_mem_cfg;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             config_en = 1'b0;
  logic             config_in = 1'b0;
  logic             config_out;
  logic [WIDTH-1:0] in0 = '0;
  logic [WIDTH-1:0] in1 = '0;
  logic             we = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out0;
  logic             out_valid;
  logic             out_ready = 1'b0;

  always #5 clk = ~clk;

  block_mem_cfg #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .config_en (config_en),
    .config_in (config_in),
    .config_out(config_out),
    .in0       (in0),
    .in1       (in1),
    .we        (we),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out0      (out0),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // Behavioural model state
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_mem [DEPTH];
  int               cfg_hist[$];   // shifted config bits, newest first
  bit               pend_cfg;
  bit               pend_cfg_bit;
  bit               pend_push;
  logic [WIDTH-1:0] pend_data;
  bit               mon_en = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [WIDTH-1:0] act,
                     input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // k-th most recently shifted bit; bits never shifted are the reset zeros.
  function automatic bit cfg_bit(input int k);
    if (k < cfg_hist.size()) return cfg_hist[k] != 0;
    return 1'b0;
  endfunction

  // Newest bit is cfg[2], next cfg[1], oldest of three cfg[0].
  function automatic bit m_ram();
    return cfg_bit(2) && !cfg_bit(0) && cfg_bit(1);
  endfunction

  function automatic bit m_fifo();
    return cfg_bit(2) && cfg_bit(0) && !cfg_bit(1);
  endfunction

  // Apply the effect of the edge that just happened to the model.
  task automatic commit();
    if (pend_cfg) begin
      cfg_hist.push_front(int'(pend_cfg_bit));
      if (cfg_hist.size() > 3) void'(cfg_hist.pop_back());
      exp_q.delete();
    end else if (pend_push) begin
      exp_q.push_back(pend_data);
    end
    pend_cfg  = 1'b0;
    pend_push = 1'b0;
  endtask

  task automatic step(input bit cen, input bit cin, input bit iv,
                      input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] a1,
                      input bit w, input bit ordy);
    bit exp_rdy;
    int idx;
    @(posedge clk);
    #1;
    commit();
    config_en = cen;
    config_in = cin;
    in_valid  = iv;
    in0       = a0;
    in1       = a1;
    we        = w;
    out_ready = ordy;
    #1;
    exp_rdy = 1'b0;
    if (!cen) begin
      if (m_ram())       exp_rdy = (exp_q.size() == 0) || ordy;
      else if (m_fifo()) exp_rdy = (exp_q.size() != DEPTH);
    end
    chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
    chk("config_out", {31'b0, config_out}, {31'b0, cfg_bit(2)});
    pend_cfg     = cen;
    pend_cfg_bit = cin;
    pend_push    = 1'b0;
    if (iv && exp_rdy) begin
      idx = int'(a0 % DEPTH);
      if (m_ram()) begin
        if (w) m_mem[idx] = a1;
        else begin
          pend_push = 1'b1;
          pend_data = m_mem[idx];
        end
      end else begin
        pend_push = 1'b1;
        pend_data = a0;
      end
    end
  endtask

  task automatic idle(input bit ordy);
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, ordy);
  endtask

  task automatic load_cfg(input logic [2:0] c);
    for (int i = 0; i < 3; i++) step(1'b1, c[i], 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic ram_wr(input int a, input logic [WIDTH-1:0] d);
    step(1'b0, 1'b0, 1'b1, WIDTH'(a), d, 1'b1, 1'b1);
  endtask

  task automatic ram_rd(input int a, input bit ordy);
    step(1'b0, 1'b0, 1'b1, WIDTH'(a), '0, 1'b0, ordy);
  endtask

  task automatic push(input logic [WIDTH-1:0] d, input bit ordy);
    step(1'b0, 1'b0, 1'b1, d, '0, 1'b0, ordy);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);
  endtask

  // Reset asserted between edges; outputs must drop at once.
  task automatic async_reset();
    @(posedge clk);
    #1;
    commit();
    config_en = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, '0);
    chk("rst_out0", out0, '0);
    chk("rst_config_out", {31'b0, config_out}, '0);
    exp_q.delete();
    cfg_hist.delete();
    pend_cfg  = 1'b0;
    pend_push = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b1;
  endtask

  // Monitor: compare whatever the DUT presents against the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && reset) begin
        chk("out_valid", {31'b0, out_valid}, {31'b0, (exp_q.size() != 0)});
        if (out_valid && exp_q.size() != 0) begin
          chk("out0", out0, exp_q[0]);
          if (out_ready && !config_en) void'(exp_q.pop_front());
        end else if (!out_valid) begin
          chk("out0_zero", out0, '0);
        end
      end
    end
  end

  initial begin
    pend_cfg  = 1'b0;
    pend_push = 1'b0;
    in_valid  = 1'b1;
    #3;
    chk("init_out_valid", {31'b0, out_valid}, '0);
    chk("init_out0", out0, '0);
    chk("init_config_out", {31'b0, config_out}, '0);
    chk("init_in_ready", {31'b0, in_ready}, '0);
    in_valid = 1'b0;
    #20;
    reset  = 1'b1;
    mon_en = 1'b1;

    // Config chain: 1,1,0 -> enable + RAM
    load_cfg(3'b011);

    // Fill the array so every later read has a known value
    for (int a = 0; a < DEPTH; a++) ram_wr(a, $urandom);
    ram_wr(5, 32'hDEADBEEF);
    ram_rd(5, 1'b1);
    idle(1'b1);

    // Backpressure: result held for three cycles, further reads refused
    ram_rd(5, 1'b0);
    for (int i = 0; i < 3; i++) ram_rd(7, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Random RAM traffic
    for (int i = 0; i < 300; i++)
      step(1'b0, 1'b0, ($urandom % 4) != 0, $urandom, $urandom,
           ($urandom % 2) != 0, ($urandom % 3) != 0);
    drain();

    // Config chain continues: config_out replays 1,1,0; result is FIFO mode
    load_cfg(3'b101);

    // Fill to full, refused push with pop, empty, then wrap
    for (int i = 0; i < DEPTH; i++) push(WIDTH'(i), 1'b0);
    push(WIDTH'(16), 1'b1);
    drain();
    for (int i = 0; i < 8; i++) push(WIDTH'(100 + i), 1'b0);
    drain();

    // Simultaneous push and pop at occupancy 4
    for (int i = 0; i < 4; i++) push(WIDTH'(200 + i), 1'b0);
    push(WIDTH'(204), 1'b1);
    idle(1'b0);
    drain();

    // Random FIFO traffic
    for (int i = 0; i < 400; i++)
      step(1'b0, 1'b0, ($urandom % 3) != 0, $urandom, '0, 1'b0,
           ($urandom % 2) != 0);
    drain();

    // Config shift with occupancy 5: no transfer, FIFO emptied
    for (int i = 0; i < 5; i++) push(WIDTH'(300 + i), 1'b0);
    step(1'b1, 1'b1, 1'b1, WIDTH'(999), '0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, WIDTH'(998), '0, 1'b0, 1'b1);
    load_cfg(3'b101);
    idle(1'b1);
    push(WIDTH'(400), 1'b0);
    push(WIDTH'(401), 1'b1);
    drain();

    // Asynchronous reset with occupancy 5
    for (int i = 0; i < 5; i++) push(WIDTH'(500 + i), 1'b0);
    async_reset();
    push(WIDTH'(600), 1'b1);
    idle(1'b1);
    idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
